// File: rtl/edge_cache_if.sv
// Bundle for the edge_cache query port (ec_*) and its pipelined read master (mem_*).
//   master modport: the Dijkstra core plus the memory system, i.e. everything around the cache.
//   slave modport:  the edge_cache itself.
// Signals:
//   ec_query, ec_from_node, ec_to_node  lookup session and requested edge
//   ec_ready, ec_edge_value             registered lookup result
//   mem_read, mem_address               read request (held while mem_waitrequest)
//   mem_waitrequest                     request stalled
//   mem_readdatavalid, mem_readdata     in-order read responses
interface edge_cache_if #(
  parameter int unsigned INDEX_WIDTH    = 8,
  parameter int unsigned VALUE_WIDTH    = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 32
);
  logic                      ec_query;
  logic [INDEX_WIDTH-1:0]    ec_from_node;
  logic [INDEX_WIDTH-1:0]    ec_to_node;
  logic                      ec_ready;
  logic [VALUE_WIDTH-1:0]    ec_edge_value;
  logic                      mem_read;
  logic [MEM_ADDR_WIDTH-1:0] mem_address;
  logic                      mem_waitrequest;
  logic                      mem_readdatavalid;
  logic [VALUE_WIDTH-1:0]    mem_readdata;

  modport master (
    output ec_query, ec_from_node, ec_to_node,
    input  ec_ready, ec_edge_value,
    input  mem_read, mem_address,
    output mem_waitrequest, mem_readdatavalid, mem_readdata
  );

  modport slave (
    input  ec_query, ec_from_node, ec_to_node,
    output ec_ready, ec_edge_value,
    output mem_read, mem_address,
    input  mem_waitrequest, mem_readdatavalid, mem_readdata
  );
endinterface

// File: rtl/edge_cache.sv
// Edge-weight server for the Dijkstra core. On a query for a source node it fetches that
// node's adjacency-matrix row (row-major N x N, VALUE_WIDTH-bit words) over a pipelined read
// master into a single-row buffer, then answers per-destination lookups from the buffer.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   base_address     byte address of matrix element [0][0]
//   number_of_nodes  N, row length (clamped to MAX_NODES)
//   bus              edge_cache_if.slave: ec_* query port and mem_* read master
module edge_cache #(
  parameter int unsigned MAX_NODES      = 16,
  parameter int unsigned INDEX_WIDTH    = 8,
  parameter int unsigned VALUE_WIDTH    = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [MEM_ADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0]    number_of_nodes,
  edge_cache_if.slave               bus
);

  localparam int unsigned CntWidth = $clog2(MAX_NODES + 1);
  localparam int unsigned RowWidth = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int unsigned Shift    = $clog2(VALUE_WIDTH / 8);
  // Largest positive value: the core's adder can add two of these without wrapping.
  localparam logic [VALUE_WIDTH-1:0] NoEdge = {1'b0, {(VALUE_WIDTH - 1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StRequest, StCollect, StServe} state_e;

  state_e                   state_q;
  logic [INDEX_WIDTH-1:0]   tag_q;
  logic                     row_valid_q;
  logic [CntWidth-1:0]      neff_q;
  logic [CntWidth-1:0]      issue_q;
  logic [CntWidth-1:0]      resp_q;
  logic [INDEX_WIDTH-1:0]   to_q;
  logic [VALUE_WIDTH-1:0]   row_q [MAX_NODES];

  logic [CntWidth-1:0]      neff_in;
  logic                     start_fetch;
  logic                     issue_fire;
  logic                     resp_fire;
  logic [CntWidth-1:0]      issue_next;
  logic [CntWidth-1:0]      resp_next;
  logic [VALUE_WIDTH-1:0]   raw;
  logic [VALUE_WIDTH-1:0]   lookup_value;

  function automatic logic [MEM_ADDR_WIDTH-1:0] word_addr(
    input logic [MEM_ADDR_WIDTH-1:0] base,
    input logic [INDEX_WIDTH-1:0]    row,
    input logic [CntWidth-1:0]       n,
    input logic [CntWidth-1:0]       k
  );
    return base + ((MEM_ADDR_WIDTH'(row) * MEM_ADDR_WIDTH'(n) + MEM_ADDR_WIDTH'(k)) << Shift);
  endfunction

  always_comb begin
    neff_in = (32'(number_of_nodes) > MAX_NODES) ? CntWidth'(MAX_NODES)
                                                 : CntWidth'(number_of_nodes);

    // Miss from IDLE, or a change of source node while serving.
    start_fetch = bus.ec_query &&
                  (((state_q == StIdle) && !(row_valid_q && (tag_q == bus.ec_from_node))) ||
                   ((state_q == StServe) && (tag_q != bus.ec_from_node)));

    issue_fire = bus.mem_read && !bus.mem_waitrequest;
    issue_next = issue_q + CntWidth'(1);

    // Responses outside a fetch (e.g. stragglers after reset) are dropped.
    resp_fire = bus.mem_readdatavalid && (resp_q < neff_q) &&
                ((state_q == StRequest) || (state_q == StCollect));
    resp_next = resp_q + CntWidth'(resp_fire);

    raw = row_q[bus.ec_to_node[RowWidth-1:0]];
    if (32'(bus.ec_to_node) >= 32'(neff_q)) begin
      lookup_value = NoEdge;
    end else if (bus.ec_to_node == tag_q) begin
      lookup_value = '0;
    end else if (raw == '0) begin
      lookup_value = NoEdge;
    end else begin
      lookup_value = raw;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= StIdle;
      tag_q             <= '0;
      row_valid_q       <= 1'b0;
      neff_q            <= '0;
      issue_q           <= '0;
      resp_q            <= '0;
      to_q              <= '0;
      bus.ec_ready      <= 1'b0;
      bus.ec_edge_value <= '0;
      bus.mem_read      <= 1'b0;
      bus.mem_address   <= '0;
    end else begin
      to_q <= bus.ec_to_node;

      if (resp_fire) begin
        row_q[resp_q[RowWidth-1:0]] <= bus.mem_readdata;
        resp_q                      <= resp_next;
      end

      if (start_fetch) begin
        tag_q           <= bus.ec_from_node;
        row_valid_q     <= 1'b0;
        neff_q          <= neff_in;
        issue_q         <= '0;
        resp_q          <= '0;
        bus.mem_read    <= (neff_in != '0);
        bus.mem_address <= word_addr(base_address, bus.ec_from_node, neff_in, '0);
        bus.ec_ready    <= 1'b0;
        state_q         <= StRequest;
      end else begin
        unique case (state_q)
          StIdle: begin
            bus.ec_ready <= 1'b0;
            if (bus.ec_query) state_q <= StServe;  // hit: start_fetch was low
          end
          StRequest: begin
            if (neff_q == '0) begin
              state_q <= StCollect;
            end else if (issue_fire) begin
              issue_q <= issue_next;
              if (issue_next == neff_q) begin
                bus.mem_read <= 1'b0;
                state_q      <= StCollect;
              end else begin
                bus.mem_address <= word_addr(base_address, tag_q, neff_q, issue_next);
              end
            end
          end
          StCollect: begin
            if (resp_next == neff_q) begin
              row_valid_q <= 1'b1;
              state_q     <= bus.ec_query ? StServe : StIdle;
            end
          end
          StServe: begin
            if (!bus.ec_query) begin
              bus.ec_ready <= 1'b0;
              state_q      <= StIdle;
            end else begin
              // Ready only once ec_to_node has been stable for a cycle.
              bus.ec_ready      <= (bus.ec_to_node == to_q);
              bus.ec_edge_value <= lookup_value;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_cache.sv
module tb_edge_cache;
  localparam int unsigned MAXN = 16;
  localparam int unsigned IW   = 8;
  localparam int unsigned VW   = 32;
  localparam int unsigned AW   = 32;
  localparam logic [31:0] NO_EDGE = 32'h7FFF_FFFF;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] base_address;
  logic [IW-1:0] number_of_nodes;

  edge_cache_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .MEM_ADDR_WIDTH(AW)) bus ();

  edge_cache #(
    .MAX_NODES(MAXN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .MEM_ADDR_WIDTH(AW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .base_address    (base_address),
    .number_of_nodes (number_of_nodes),
    .bus             (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents: every word encodes its own address, except one stored zero at 0x124.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h124) return 32'h0;
    return {16'hBEEF, a[15:0]};
  endfunction

  // Pipelined memory model driven on the falling edge; responses survive a DUT reset.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] acc[$];
  int cyc = 0, lat = 2, stall_at = -1, stall_left = 0, stall_124 = 0, read_cycles = 0;

  always @(negedge clock) begin
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_readdatavalid = 1'b1;
      bus.mem_readdata      = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      bus.mem_readdatavalid = 1'b0;
      bus.mem_readdata      = '0;
    end
    if (bus.mem_read && acc.size() == stall_at && stall_left > 0) begin
      bus.mem_waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.mem_waitrequest = 1'b0;
    end
    if (bus.mem_read) read_cycles++;
    if (bus.mem_read && bus.mem_waitrequest && bus.mem_address == 32'h124) stall_124++;
    if (bus.mem_read && !bus.mem_waitrequest) begin
      acc.push_back(bus.mem_address);
      pend.push_back('{addr: bus.mem_address, due: cyc + lat});
    end
  end

  task automatic wait_ready(input string name, input int budget);
    int i = 0;
    while (bus.ec_ready !== 1'b1 && i < budget) begin
      @(negedge clock);
      i++;
    end
    check(name, bus.ec_ready, 1);
  endtask

  // Change ec_to_node: one cycle with ready low, then ready high with the mapped weight.
  task automatic lookup(input string name, input logic [7:0] to, input logic [31:0] exp);
    bus.ec_to_node = to;
    @(negedge clock);
    check({name, " gap"}, bus.ec_ready, 0);
    @(negedge clock);
    check({name, " ready"}, bus.ec_ready, 1);
    check({name, " value"}, bus.ec_edge_value, exp);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  to;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep[5];

  initial begin
    int rc0;
    sweep[0] = '{name: "row2 to0", to: 8'd0, exp: 32'hBEEF_0120};
    sweep[1] = '{name: "row2 to1 zero", to: 8'd1, exp: NO_EDGE};
    sweep[2] = '{name: "row2 to2 self", to: 8'd2, exp: 32'h0};
    sweep[3] = '{name: "row2 to3", to: 8'd3, exp: 32'hBEEF_012C};
    sweep[4] = '{name: "row2 to7 range", to: 8'd7, exp: NO_EDGE};

    reset = 1'b1;
    base_address = 32'h100;
    number_of_nodes = 8'd4;
    bus.ec_query = 1'b0;
    bus.ec_from_node = '0;
    bus.ec_to_node = 8'd3;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata = '0;
    repeat (3) @(negedge clock);
    check("reset ec_ready", bus.ec_ready, 0);
    check("reset ec_edge_value", bus.ec_edge_value, 0);
    check("reset mem_read", bus.mem_read, 0);
    check("reset mem_address", bus.mem_address, 0);
    reset = 1'b0;
    @(negedge clock);

    // 1) Fetch row 2 of a 4x4 matrix at 0x100.
    acc.delete();
    bus.ec_from_node = 8'd2;
    bus.ec_query = 1'b1;
    wait_ready("fetch row2 ready", 100);
    check("fetch row2 count", acc.size(), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++)
      check($sformatf("fetch row2 addr%0d", i), acc[i], 32'h120 + 32'(4 * i));

    // 2) Column sweep.
    for (int i = 0; i < 5; i++) lookup(sweep[i].name, sweep[i].to, sweep[i].exp);

    // 3) Drop and re-query the cached row: no memory traffic, ready after 2 cycles.
    bus.ec_query = 1'b0;
    repeat (2) @(negedge clock);
    check("drop ready low", bus.ec_ready, 0);
    rc0 = read_cycles;
    bus.ec_query = 1'b1;
    @(negedge clock);
    check("hit cycle1 ready", bus.ec_ready, 0);
    @(negedge clock);
    check("hit cycle2 ready", bus.ec_ready, 1);
    check("hit cycle2 value", bus.ec_edge_value, NO_EDGE);
    repeat (3) @(negedge clock);
    check("hit no mem_read", read_cycles - rc0, 0);

    // 4) Fetch row 0, then switch to row 2 while serving; stall the 2nd request 3 cycles.
    bus.ec_from_node = 8'd0;
    @(negedge clock);
    wait_ready("row0 ready", 100);
    acc.delete();
    stall_at = 1;
    stall_left = 3;
    stall_124 = 0;
    bus.ec_from_node = 8'd2;
    @(negedge clock);
    check("refetch drops ready", bus.ec_ready, 0);
    wait_ready("stall ready", 100);
    check("stall count", acc.size(), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++)
      check($sformatf("stall addr%0d", i), acc[i], 32'h120 + 32'(4 * i));
    check("stall held 0x124", stall_124, 3);
    lookup("stall to3", 8'd3, 32'hBEEF_012C);

    // 5) N=40 clamps to 16 reads.
    number_of_nodes = 8'd40;
    acc.delete();
    bus.ec_from_node = 8'd1;
    @(negedge clock);
    wait_ready("clamp ready", 200);
    check("clamp count", acc.size(), 16);
    if (acc.size() == 16) begin
      check("clamp first addr", acc[0], 32'h140);
      check("clamp last addr", acc[15], 32'h17C);
    end
    lookup("clamp to15", 8'd15, 32'hBEEF_017C);
    lookup("clamp to16", 8'd16, NO_EDGE);

    // 6) Reset after 2 accepted requests; stragglers must not disturb the next fetch.
    number_of_nodes = 8'd4;
    bus.ec_query = 1'b0;
    repeat (2) @(negedge clock);
    lat = 4;
    acc.delete();
    bus.ec_from_node = 8'd3;
    bus.ec_query = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      #1;
      if (acc.size() >= 2) break;
    end
    reset = 1'b1;
    bus.ec_query = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("midreset ready", bus.ec_ready, 0);
    check("midreset mem_read", bus.mem_read, 0);
    check("midreset mem_address", bus.mem_address, 0);
    rc0 = read_cycles;
    repeat (8) @(negedge clock);
    check("idle after reset no reads", read_cycles - rc0, 0);
    lat = 2;
    acc.delete();
    bus.ec_from_node = 8'd1;
    bus.ec_query = 1'b1;
    wait_ready("post-reset ready", 100);
    check("post-reset count", acc.size(), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++)
      check($sformatf("post-reset addr%0d", i), acc[i], 32'h110 + 32'(4 * i));
    lookup("post-reset to0", 8'd0, 32'hBEEF_0110);
    lookup("post-reset to2", 8'd2, 32'hBEEF_0118);
    lookup("post-reset to1 self", 8'd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
